// File: rtl/uart_alu_interface.sv
`default_nettype none
// ============================================================================
// uart_alu_interface : collects A, B, opcode bytes from the UART receiver,
// drives the ALU and sends its result back through the UART transmitter.
// Rev 1.0
// ============================================================================
module uart_alu_interface #(
  parameter int NB_DATA  = 8,
  parameter int NB_CODE  = 6,
  parameter int NB_STATE = 3
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_CODE-1:0] o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_overrun
);

  typedef enum logic [NB_STATE-1:0] {
    WAIT_A  = NB_STATE'(0),
    WAIT_B  = NB_STATE'(1),
    WAIT_OP = NB_STATE'(2),
    LOAD    = NB_STATE'(3),
    SEND    = NB_STATE'(4),
    WAIT_TX = NB_STATE'(5)
  } state_t;

  state_t             state_q,    state_d;
  logic [NB_DATA-1:0] data_a_q,   data_a_d;
  logic [NB_DATA-1:0] data_b_q,   data_b_d;
  logic [NB_CODE-1:0] op_q,       op_d;
  logic [NB_DATA-1:0] tx_data_q,  tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               overrun_q,  overrun_d;

  // Opcode byte bits above NB_CODE are deliberately discarded.
  logic unused_rx_bits;
  assign unused_rx_bits = ^i_rx_data[NB_DATA-1:NB_CODE];

  always_comb begin
    state_d    = state_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    overrun_d  = 1'b0;
    case (state_q)
      WAIT_A: if (i_rx_done) begin
        data_a_d = i_rx_data;
        state_d  = WAIT_B;
      end
      WAIT_B: if (i_rx_done) begin
        data_b_d = i_rx_data;
        state_d  = WAIT_OP;
      end
      WAIT_OP: if (i_rx_done) begin
        op_d    = i_rx_data[NB_CODE-1:0];
        state_d = LOAD;
      end
      LOAD: begin
        // Result and start pulse are registered on entry so they are visible during SEND.
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        overrun_d  = i_rx_done;
        state_d    = SEND;
      end
      SEND: begin
        overrun_d = i_rx_done;
        state_d   = WAIT_TX;
      end
      WAIT_TX: begin
        overrun_d = i_rx_done;
        if (i_tx_done) state_d = WAIT_A;
      end
      default: state_d = WAIT_A;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= WAIT_A;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_op       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_overrun  = overrun_q;
  assign o_busy     = (state_q == LOAD) || (state_q == SEND) || (state_q == WAIT_TX);

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_interface.sv
`default_nettype none
// ============================================================================
// tb_uart_alu_interface : directed, table-driven bench for uart_alu_interface.
// Rev 1.0
// ============================================================================
module tb_uart_alu_interface;
  localparam int NB_DATA  = 8;
  localparam int NB_CODE  = 6;
  localparam int NB_STATE = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NB_DATA-1:0] rx_data;
  logic               rx_done;
  logic [NB_DATA-1:0] alu_result;
  logic               tx_done;
  logic [NB_DATA-1:0] o_data_a, o_data_b, o_tx_data;
  logic [NB_CODE-1:0] o_op;
  logic               o_tx_start, o_busy, o_overrun;

  int tests = 0;
  int fails = 0;
  int tx_pulses = 0;

  always #5 clk = ~clk;

  uart_alu_interface #(
    .NB_DATA (NB_DATA),
    .NB_CODE (NB_CODE),
    .NB_STATE(NB_STATE)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_done   (rx_done),
    .i_alu_result(alu_result),
    .i_tx_done   (tx_done),
    .o_data_a    (o_data_a),
    .o_data_b    (o_data_b),
    .o_op        (o_op),
    .o_tx_data   (o_tx_data),
    .o_tx_start  (o_tx_start),
    .o_busy      (o_busy),
    .o_overrun   (o_overrun)
  );

  // Stand-in ALU: a small subset of MIPS-style function codes.
  always_comb begin
    case (o_op)
      6'h20:   alu_result = o_data_a + o_data_b;
      6'h22:   alu_result = o_data_a - o_data_b;
      6'h24:   alu_result = o_data_a & o_data_b;
      6'h25:   alu_result = o_data_a | o_data_b;
      default: alu_result = 8'h00;
    endcase
  end

  always @(negedge clk) if (o_tx_start === 1'b1) tx_pulses++;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] opb;
    logic [5:0] exp_op;
    logic [7:0] exp_res;
    string      name;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " data_a"},   32'(o_data_a),   32'h0);
    check({tag, " data_b"},   32'(o_data_b),   32'h0);
    check({tag, " op"},       32'(o_op),       32'h0);
    check({tag, " tx_data"},  32'(o_tx_data),  32'h0);
    check({tag, " tx_start"}, 32'(o_tx_start), 32'h0);
    check({tag, " busy"},     32'(o_busy),     32'h0);
    check({tag, " overrun"},  32'(o_overrun),  32'h0);
  endtask

  // Sends one triple and checks the 2-cycle opcode-to-start latency; ends in WAIT_TX.
  task automatic run_triple(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                            input logic [5:0] exp_op, input logic [7:0] exp_res,
                            input string tag);
    int p0;
    send_byte(a);
    check({tag, " data_a"}, 32'(o_data_a), 32'(a));
    check({tag, " busy@B"}, 32'(o_busy), 32'h0);
    send_byte(b);
    check({tag, " data_b"}, 32'(o_data_b), 32'(b));
    check({tag, " data_a hold"}, 32'(o_data_a), 32'(a));
    p0 = tx_pulses;
    send_byte(opb);
    check({tag, " op"}, 32'(o_op), 32'(exp_op));
    check({tag, " busy@load"}, 32'(o_busy), 32'h1);
    check({tag, " start@n+1"}, 32'(o_tx_start), 32'h0);
    tick();
    check({tag, " start@n+2"}, 32'(o_tx_start), 32'h1);
    check({tag, " tx_data"}, 32'(o_tx_data), 32'(exp_res));
    tick();
    check({tag, " start@n+3"}, 32'(o_tx_start), 32'h0);
    check({tag, " busy@wtx"}, 32'(o_busy), 32'h1);
    check({tag, " tx_data hold"}, 32'(o_tx_data), 32'(exp_res));
    check({tag, " start count"}, 32'(tx_pulses - p0), 32'h1);
  endtask

  task automatic finish_tx(input string tag);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check({tag, " busy after tx_done"}, 32'(o_busy), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] prev_a;
    vecs[0] = '{8'h03, 8'h08, 8'h20, 6'h20, 8'h0B, "add"};
    vecs[1] = '{8'h08, 8'h03, 8'h22, 6'h22, 8'h05, "sub"};
    vecs[2] = '{8'h03, 8'h08, 8'hE0, 6'h20, 8'h0B, "mask"};
    vecs[3] = '{8'hF0, 8'h3C, 8'h24, 6'h24, 8'h30, "and"};
    vecs[4] = '{8'hF0, 8'h0F, 8'h25, 6'h25, 8'hFF, "or"};
    vecs[5] = '{8'h10, 8'h20, 8'h3F, 6'h3F, 8'h00, "op3f"};

    rst_n   = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tx_done = 1'b0;
    tick(); tick(); tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    prev_a = 8'h00;
    for (int i = 0; i < 6; i++) begin
      check({vecs[i].name, " data_a before"}, 32'(o_data_a), 32'(prev_a));
      run_triple(vecs[i].a, vecs[i].b, vecs[i].opb, vecs[i].exp_op, vecs[i].exp_res, vecs[i].name);
      finish_tx(vecs[i].name);
      prev_a = vecs[i].a;
    end

    // Byte arriving while a result is in flight.
    run_triple(8'h03, 8'h08, 8'h20, 6'h20, 8'h0B, "ovr");
    rx_data = 8'h55;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    check("ovr overrun", 32'(o_overrun), 32'h1);
    check("ovr data_a", 32'(o_data_a), 32'h03);
    check("ovr busy", 32'(o_busy), 32'h1);
    tick();
    check("ovr overrun clear", 32'(o_overrun), 32'h0);
    finish_tx("ovr");
    run_triple(8'h01, 8'h02, 8'h20, 6'h20, 8'h03, "ovr next");
    finish_tx("ovr next");

    // rx_done and tx_done in the same WAIT_TX cycle.
    run_triple(8'h04, 8'h05, 8'h20, 6'h20, 8'h09, "sim");
    rx_data = 8'h77;
    rx_done = 1'b1;
    tx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tx_done = 1'b0;
    check("sim overrun", 32'(o_overrun), 32'h1);
    check("sim busy", 32'(o_busy), 32'h0);
    check("sim data_a", 32'(o_data_a), 32'h04);
    tick();
    check("sim overrun clear", 32'(o_overrun), 32'h0);
    check("sim data_a idle", 32'(o_data_a), 32'h04);
    run_triple(8'h06, 8'h07, 8'h22, 6'h22, 8'hFF, "sim next");
    finish_tx("sim next");

    // Asynchronous reset after A and B collected.
    send_byte(8'h03);
    send_byte(8'h08);
    check("rstab data_b", 32'(o_data_b), 32'h08);
    #2 rst_n = 1'b0;
    #1 check_zero("rstab");
    tick();
    rst_n = 1'b1;
    tick();
    run_triple(8'h01, 8'h02, 8'h20, 6'h20, 8'h03, "rstab next");
    finish_tx("rstab next");

    // Asynchronous reset during WAIT_TX.
    run_triple(8'h03, 8'h08, 8'h20, 6'h20, 8'h0B, "rsttx");
    #2 rst_n = 1'b0;
    #1 check_zero("rsttx");
    tick();
    rst_n = 1'b1;
    tick();
    run_triple(8'h01, 8'h02, 8'h20, 6'h20, 8'h03, "rsttx next");
    finish_tx("rsttx next");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
